qed_dup_sequencer: RTL and testbench
====================================

// Module: qed_dup_sequencer
// PURPOSE
//  Phase controller for the QED instruction path. Sequences an ORIG phase (original instructions issued),
//  a DUP phase (exec_dup high, duplicates replayed from the QED i-cache) and a WAIT phase (fetch held
//  until originals and duplicates have all committed). Pulses qed_ready when the commit counts match.
//  Sits beside the qed top level, driving its exec_dup input and consuming its vld_out.
// PARAMETERS
//  MAX_ORIG  8      max originals per round (= QED i-cache depth); forces the switch to DUP
//  CNT_W     4      counter width; must satisfy 2**CNT_W > MAX_ORIG
//  TIMEOUT   64     max WAIT cycles before qed_err is set
// PORTS
//  clk          in  1      clock
//  rst          in  1      reset, synchronous, active-high
//  ena          in  1      QED mode enable
//  stall_IF     in  1      fetch stall; no issue is counted while high
//  ifu_vld      in  1      original instruction present at IF this cycle
//  qic_vld      in  1      QED i-cache holds a duplicate (qed vld_out)
//  dup_req      in  1      request an early switch to DUP (free input under formal)
//  orig_commit  in  1      one original retired this cycle
//  dup_commit   in  1      one duplicate retired this cycle
//  exec_dup     out 1      registered; high throughout DUP
//  qed_hold     out 1      registered; high in WAIT; stalls fetch
//  qed_ready    out 1      one-cycle pulse: round complete, commit counts equal
//  qed_err      out 1      sticky: commit overflow or WAIT timeout
//  phase        out 2      00 IDLE, 01 ORIG, 10 DUP, 11 WAIT
//  orig_issued  out CNT_W  originals issued in the current round
// BEHAVIOUR
//  Reset: phase=IDLE; exec_dup, qed_hold, qed_ready, qed_err=0; all counters=0. Takes effect at the next
//   edge from any state (mid-round included); no partial round survives.
//  Issue events: o_fire = ifu_vld & ~stall_IF (ORIG only); d_fire = qic_vld & ~stall_IF (DUP only).
//  IDLE: ena=1 -> ORIG at the next edge.
//  ORIG: o_fire increments orig_issued.
//   -> DUP when orig_issued+o_fire == MAX_ORIG, or when dup_req & ~stall_IF & orig_issued+o_fire >= 1.
//   -> IDLE when ena=0 and orig_issued==0.
//   dup_req with orig_issued==0 and no o_fire is ignored.
//  DUP: exec_dup=1 from the first DUP cycle (registered, 1-cycle latency from the transition edge).
//   d_fire increments dup_issued. -> WAIT when dup_issued+d_fire == orig_issued.
//   stall_IF holds all state; exec_dup stays high.
//  WAIT: qed_hold=1, exec_dup=0.
//   Completion: orig_cmt == dup_cmt == orig_issued -> qed_ready=1 for exactly one cycle.
//   On completion, clear all counters and the wait timer. Next phase is ORIG if ena else IDLE.
//  Commit counters:
//   - orig_cmt and dup_cmt count in every phase except IDLE.
//   - Simultaneous orig_commit and dup_commit both count in the same cycle.
//   - A commit that would exceed orig_issued sets qed_err; the counter saturates at orig_issued.
//  Wait timer: counts WAIT cycles; at TIMEOUT, qed_err=1 and the FSM stays in WAIT.
//   qed_err persists until rst.
//  ena=0 outside ORIG/IDLE does not abort the round; it only suppresses the next ORIG.
//  Widths: all counters CNT_W bits unsigned, with no wrap by construction (bounded by MAX_ORIG).
//   Wait timer is clog2(TIMEOUT+1) bits.
// STRUCTURE
//  Shared package qed_pkg: phase localparams (PH_IDLE..PH_WAIT), CNT_W default.
//  One sub-module, qed_sat_counter (inc, clr, limit, overflow flag), instanced for orig_cmt and dup_cmt.
//   All other logic stays inline.
// TESTING
//  T1 rst held 3 cycles, ena=1 -> all outputs 0, phase=00; release -> phase=01 on the next edge.
//  T2 8 consecutive o_fire (MAX_ORIG=8) -> phase=10, exec_dup=1 on the next cycle;
//     8 d_fire -> phase=11, qed_hold=1;
//     8 orig_commit and 8 dup_commit -> qed_ready pulses once, phase=01, counters=0.
//  T3 3 o_fire then dup_req -> DUP with orig_issued=3; exactly 3 d_fire -> WAIT.
//     stall_IF asserted mid-DUP for 5 cycles -> no count, exec_dup stays 1.
//  T4 orig_commit and dup_commit pulsed in the same cycle, 2 rounds back to back -> counts correct;
//     a 4th orig_commit with orig_issued=3 -> qed_err=1, sticky.
//  T5 no commits in WAIT for 64 cycles -> qed_err=1 at cycle 64, phase stays 11.
//  T6 rst asserted in DUP with dup_issued=2 -> phase=00 and exec_dup=0 next edge;
//     ena=0 at completion -> IDLE after qed_ready.

Source files
------------

// File: rtl/qed_pkg.sv
// Shared definitions for the QED duplicate sequencer: phase encoding and default counter width.
package qed_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'b00,
        PH_ORIG = 2'b01,
        PH_DUP  = 2'b10,
        PH_WAIT = 2'b11
    } phase_t;

    localparam int QED_CNT_W = 4;

endpackage

// File: rtl/qed_sat_counter.sv
// Commit counter that saturates at a moving limit and flags any increment attempted at or past it.
module qed_sat_counter
    import qed_pkg::*;
#(
    parameter int W = QED_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A commit arriving with the count already at the limit retires more than was issued.
    assign ovf = inc && (cnt_q >= limit);
    assign cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/qed_dup_sequencer.sv
// Phase controller for the QED instruction path: ORIG issue, DUP replay, WAIT for commits.
module qed_dup_sequencer
    import qed_pkg::*;
#(
    parameter int MAX_ORIG = 8,
    parameter int CNT_W    = QED_CNT_W,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             stall_IF,
    input  logic             ifu_vld,
    input  logic             qic_vld,
    input  logic             dup_req,
    input  logic             orig_commit,
    input  logic             dup_commit,
    output logic             exec_dup,
    output logic             qed_hold,
    output logic             qed_ready,
    output logic             qed_err,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] orig_issued
);

    localparam int               TMR_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MAX_ORIG_C = CNT_W'(MAX_ORIG);
    localparam logic [TMR_W-1:0] TIMEOUT_C  = TMR_W'(TIMEOUT);

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] orig_issued_q, orig_issued_d;
    logic [CNT_W-1:0] dup_issued_q, dup_issued_d;
    logic [TMR_W-1:0] wait_tmr_q, wait_tmr_d;
    logic             exec_dup_q, exec_dup_d;
    logic             qed_hold_q, qed_hold_d;
    logic             qed_ready_q, qed_ready_d;
    logic             qed_err_q, qed_err_d;

    logic             o_fire, d_fire, done, cnt_clr;
    logic [CNT_W-1:0] orig_sum, dup_sum, orig_cmt, dup_cmt;
    logic             orig_ovf, dup_ovf;

    assign o_fire   = ifu_vld && !stall_IF && (phase_q == PH_ORIG);
    assign d_fire   = qic_vld && !stall_IF && (phase_q == PH_DUP);
    assign orig_sum = orig_issued_q + {{(CNT_W-1){1'b0}}, o_fire};
    assign dup_sum  = dup_issued_q + {{(CNT_W-1){1'b0}}, d_fire};
    assign done     = (phase_q == PH_WAIT) && (orig_cmt == orig_issued_q)
                      && (dup_cmt == orig_issued_q);

    qed_sat_counter #(.W(CNT_W)) u_orig_cmt (
        .clk   (clk),
        .rst   (rst),
        .inc   (orig_commit && (phase_q != PH_IDLE)),
        .clr   (cnt_clr),
        .limit (orig_issued_q),
        .cnt   (orig_cmt),
        .ovf   (orig_ovf)
    );

    qed_sat_counter #(.W(CNT_W)) u_dup_cmt (
        .clk   (clk),
        .rst   (rst),
        .inc   (dup_commit && (phase_q != PH_IDLE)),
        .clr   (cnt_clr),
        .limit (orig_issued_q),
        .cnt   (dup_cmt),
        .ovf   (dup_ovf)
    );

    always_comb begin
        phase_d       = phase_q;
        orig_issued_d = orig_issued_q;
        dup_issued_d  = dup_issued_q;
        wait_tmr_d    = '0;
        cnt_clr       = 1'b0;
        qed_err_d     = qed_err_q || orig_ovf || dup_ovf;
        case (phase_q)
            PH_IDLE: begin
                if (ena) phase_d = PH_ORIG;
            end
            PH_ORIG: begin
                orig_issued_d = orig_sum;
                if (orig_sum == MAX_ORIG_C) begin
                    phase_d = PH_DUP;
                end else if (dup_req && !stall_IF && (orig_sum != '0)) begin
                    phase_d = PH_DUP;
                end else if (!ena && (orig_sum == '0)) begin
                    phase_d = PH_IDLE;
                end
            end
            PH_DUP: begin
                dup_issued_d = dup_sum;
                if (dup_sum == orig_issued_q) phase_d = PH_WAIT;
            end
            PH_WAIT: begin
                if (done) begin
                    phase_d       = ena ? PH_ORIG : PH_IDLE;
                    orig_issued_d = '0;
                    dup_issued_d  = '0;
                    cnt_clr       = 1'b1;
                end else begin
                    // Timer saturates so the error stays asserted while the round is stuck.
                    wait_tmr_d = (wait_tmr_q == TIMEOUT_C) ? wait_tmr_q : wait_tmr_q + 1'b1;
                    if (wait_tmr_d == TIMEOUT_C) qed_err_d = 1'b1;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
        exec_dup_d  = (phase_d == PH_DUP);
        qed_hold_d  = (phase_d == PH_WAIT);
        qed_ready_d = done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= PH_IDLE;
            orig_issued_q <= '0;
            dup_issued_q  <= '0;
            wait_tmr_q    <= '0;
            exec_dup_q    <= 1'b0;
            qed_hold_q    <= 1'b0;
            qed_ready_q   <= 1'b0;
            qed_err_q     <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            orig_issued_q <= orig_issued_d;
            dup_issued_q  <= dup_issued_d;
            wait_tmr_q    <= wait_tmr_d;
            exec_dup_q    <= exec_dup_d;
            qed_hold_q    <= qed_hold_d;
            qed_ready_q   <= qed_ready_d;
            qed_err_q     <= qed_err_d;
        end
    end

    assign exec_dup    = exec_dup_q;
    assign qed_hold    = qed_hold_q;
    assign qed_ready   = qed_ready_q;
    assign qed_err     = qed_err_q;
    assign phase       = phase_q;
    assign orig_issued = orig_issued_q;

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Directed bench for qed_dup_sequencer with hand-computed expectations for each round.
module tb_qed_dup_sequencer;

    logic       clk = 1'b0;
    logic       rst, ena, stall_IF, ifu_vld, qic_vld, dup_req, orig_commit, dup_commit;
    logic       exec_dup, qed_hold, qed_ready, qed_err;
    logic [1:0] phase;
    logic [3:0] orig_issued;

    int total = 0;
    int bad   = 0;

    qed_dup_sequencer #(.MAX_ORIG(8), .CNT_W(4), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .stall_IF    (stall_IF),
        .ifu_vld     (ifu_vld),
        .qic_vld     (qic_vld),
        .dup_req     (dup_req),
        .orig_commit (orig_commit),
        .dup_commit  (dup_commit),
        .exec_dup    (exec_dup),
        .qed_hold    (qed_hold),
        .qed_ready   (qed_ready),
        .qed_err     (qed_err),
        .phase       (phase),
        .orig_issued (orig_issued)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge that consumed them.
    task automatic applyStimulus(input logic e, input logic st, input logic iv, input logic qv,
                                 input logic dr, input logic oc, input logic dc);
        ena = e; stall_IF = st; ifu_vld = iv; qic_vld = qv;
        dup_req = dr; orig_commit = oc; dup_commit = dc;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; ena = 0; stall_IF = 0; ifu_vld = 0; qic_vld = 0;
        dup_req = 0; orig_commit = 0; dup_commit = 0;

        // T1: reset state, then IDLE -> ORIG on the first edge after release
        doReset(3);
        checkOutput("t1_phase", phase, 2'b00);
        checkOutput("t1_exec_dup", exec_dup, 0);
        checkOutput("t1_hold", qed_hold, 0);
        checkOutput("t1_ready", qed_ready, 0);
        checkOutput("t1_err", qed_err, 0);
        checkOutput("t1_issued", orig_issued, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_phase_orig", phase, 2'b01);

        // T2: full round at MAX_ORIG
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("t2_issued7", orig_issued, 7);
        checkOutput("t2_phase7", phase, 2'b01);
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("t2_phase_dup", phase, 2'b10);
        checkOutput("t2_exec_dup", exec_dup, 1);
        checkOutput("t2_issued8", orig_issued, 8);
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("t2_dup7_phase", phase, 2'b10);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("t2_phase_wait", phase, 2'b11);
        checkOutput("t2_hold", qed_hold, 1);
        checkOutput("t2_exec_dup_off", exec_dup, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0, 1, 1);
        checkOutput("t2_ready_early", qed_ready, 0);
        checkOutput("t2_still_wait", phase, 2'b11);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_ready", qed_ready, 1);
        checkOutput("t2_phase_orig", phase, 2'b01);
        checkOutput("t2_issued_clr", orig_issued, 0);
        checkOutput("t2_hold_off", qed_hold, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_ready_pulse", qed_ready, 0);

        // T3: early switch by dup_req, stall in DUP
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("t3_phase_dup", phase, 2'b10);
        checkOutput("t3_issued", orig_issued, 3);
        checkOutput("t3_exec_dup", exec_dup, 1);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0, 1, 0, 0, 0);
            checkOutput("t3_stall_phase", phase, 2'b10);
            checkOutput("t3_stall_exec", exec_dup, 1);
        end
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("t3_dup2_phase", phase, 2'b10);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("t3_phase_wait", phase, 2'b11);

        // T4: simultaneous commits over back-to-back rounds, then an overflow
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_r1_ready", qed_ready, 1);
        checkOutput("t4_r1_phase", phase, 2'b01);
        checkOutput("t4_r1_err", qed_err, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("t4_r2_wait", phase, 2'b11);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_r2_ready", qed_ready, 1);
        checkOutput("t4_r2_phase", phase, 2'b01);
        checkOutput("t4_r2_err", qed_err, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 1, 0);
        checkOutput("t4_err_before", qed_err, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0);
        checkOutput("t4_err_ovf", qed_err, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_r3_ready", qed_ready, 1);
        checkOutput("t4_err_sticky", qed_err, 1);

        // T5: ignored dup_req, single-issue round, then WAIT timeout
        doReset(2);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("t5_dupreq_ignored", phase, 2'b01);
        applyStimulus(1, 0, 1, 0, 1, 0, 0);
        checkOutput("t5_phase_dup", phase, 2'b10);
        checkOutput("t5_issued", orig_issued, 1);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("t5_phase_wait", phase, 2'b11);
        for (int i = 0; i < 63; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_err_63", qed_err, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_err_64", qed_err, 1);
        checkOutput("t5_phase_64", phase, 2'b11);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_err_hold", qed_err, 1);
        checkOutput("t5_phase_hold", phase, 2'b11);

        // T6: reset mid-DUP, ena low at completion, ORIG -> IDLE with nothing issued
        doReset(1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("t6_in_dup", phase, 2'b10);
        doReset(1);
        checkOutput("t6_rst_phase", phase, 2'b00);
        checkOutput("t6_rst_exec", exec_dup, 0);
        checkOutput("t6_rst_issued", orig_issued, 0);
        checkOutput("t6_rst_err", qed_err, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_orig", phase, 2'b01);
        applyStimulus(1, 0, 1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("t6_wait_no_abort", phase, 2'b11);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_ready", qed_ready, 1);
        checkOutput("t6_idle", phase, 2'b00);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_ready_off", qed_ready, 0);
        checkOutput("t6_stay_idle", phase, 2'b00);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_reorig", phase, 2'b01);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_orig_to_idle", phase, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
